// File: rtl/tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tile_sequencer
// Brief    : Sequences one TILE_SIZE x TILE_SIZE tile multiply. Accepts
//            unskewed row/column operand vectors, skews them diagonally into
//            the edge FIFOs (lane i delayed i slots, zero padded), then runs
//            the systolic array for the compute window and pulses DONE.
// Revision : 1.0 - initial release
// ============================================================================
module tile_sequencer #(
   parameter int TILE_SIZE = 8,
   parameter int DW        = 16,
   parameter int SEQ_LEN   = 3*TILE_SIZE-1,
   parameter int FILL_LEN  = SEQ_LEN+1,
   parameter int RUN_LEN   = SEQ_LEN+2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [TILE_SIZE*DW-1:0] row_in,
   input  logic [TILE_SIZE*DW-1:0] col_in,
   input  logic [2*TILE_SIZE-1:0]  fifo_full,
   output logic [TILE_SIZE*DW-1:0] r_din,
   output logic [TILE_SIZE*DW-1:0] c_din,
   output logic                    fifo_write,
   output logic                    fifo_en,
   output logic                    en,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_fill = 2'd1;
   localparam logic [1:0] c_run  = 2'd2;
   localparam logic [1:0] c_fin  = 2'd3;

   localparam logic [5:0] c_tile      = 6'(TILE_SIZE);
   localparam logic [5:0] c_fill_last = 6'(FILL_LEN-1);
   localparam logic [5:0] c_run_last  = 6'(RUN_LEN-1);

   logic [1:0] r_state;
   logic [5:0] r_fill_cnt;
   logic [5:0] r_run_cnt;

   logic w_start_acc;
   logic w_step;
   logic w_load;

   logic [TILE_SIZE*DW-1:0] w_row_tap;
   logic [TILE_SIZE*DW-1:0] w_col_tap;

   assign w_start_acc = (r_state == c_idle) && start;
   assign in_ready    = (r_state == c_fill) && (r_fill_cnt < c_tile);
   // Once all vectors are in, the sequence keeps stepping on its own to flush
   // the zero padding through the chains.
   assign w_step      = (r_state == c_fill) &&
                        ((r_fill_cnt >= c_tile) || (in_valid && in_ready));
   assign w_load      = (r_fill_cnt < c_tile);
   assign busy        = (r_state != c_idle);

   // Control FSM: phase sequencing and step/compute counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_idle;
         r_fill_cnt <= '0;
         r_run_cnt  <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (start) begin
                  r_state    <= c_fill;
                  r_fill_cnt <= '0;
                  r_run_cnt  <= '0;
               end
            end
            c_fill: begin
               if (w_step) begin
                  r_fill_cnt <= r_fill_cnt + 6'd1;
                  if (r_fill_cnt == c_fill_last) r_state <= c_run;
               end
            end
            c_run: begin
               r_run_cnt <= r_run_cnt + 6'd1;
               if (r_run_cnt == c_run_last) r_state <= c_fin;
            end
            default: begin
               // FIN is held for the DONE cycle so a START there is ignored
               if (done) r_state <= c_idle;
            end
         endcase
      end
   end

   // Per-lane skew: lane i sees its operand i steps late; lane 0 is direct
   for (genvar i = 0; i < TILE_SIZE; i++) begin : g_lane
      logic [DW-1:0] w_row_lane;
      logic [DW-1:0] w_col_lane;
      assign w_row_lane = w_load ? row_in[i*DW +: DW] : '0;
      assign w_col_lane = w_load ? col_in[i*DW +: DW] : '0;

      if (i == 0) begin : g_direct
         assign w_row_tap[i*DW +: DW] = w_row_lane;
         assign w_col_tap[i*DW +: DW] = w_col_lane;
      end else begin : g_chain
         logic [DW-1:0] r_row_sr [i];
         logic [DW-1:0] r_col_sr [i];

         // Shift chain advances only on a step; cleared on reset and new tile
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int j = 0; j < i; j++) begin
                  r_row_sr[j] <= '0;
                  r_col_sr[j] <= '0;
               end
            end else if (w_start_acc) begin
               for (int j = 0; j < i; j++) begin
                  r_row_sr[j] <= '0;
                  r_col_sr[j] <= '0;
               end
            end else if (w_step) begin
               r_row_sr[0] <= w_row_lane;
               r_col_sr[0] <= w_col_lane;
               for (int j = 1; j < i; j++) begin
                  r_row_sr[j] <= r_row_sr[j-1];
                  r_col_sr[j] <= r_col_sr[j-1];
               end
            end
         end

         assign w_row_tap[i*DW +: DW] = r_row_sr[i-1];
         assign w_col_tap[i*DW +: DW] = r_col_sr[i-1];
      end
   end

   // Registered datapath strobes and FIFO write data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_write <= 1'b0;
         fifo_en    <= 1'b0;
         en         <= 1'b0;
         done       <= 1'b0;
         r_din      <= '0;
         c_din      <= '0;
      end else begin
         fifo_write <= w_step;
         fifo_en    <= w_step || (r_state == c_run);
         en         <= (r_state == c_run);
         done       <= (r_state == c_fin) && !done;
         if (w_step) begin
            r_din <= w_row_tap;
            c_din <= w_col_tap;
         end
      end
   end

   // Sticky overflow: any full FIFO while a write is being presented
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (w_start_acc) begin
         err <= 1'b0;
      end else if (fifo_write && (|fifo_full)) begin
         err <= 1'b1;
      end
   end

endmodule
`default_nettype wire
